// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port GPR file, two write ports, same-cycle bypass, r0 = 0
// REGFILE_SCOREBOARD_EN adds the pending-write scoreboard (rd_busy, pend_cnt)
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD-1:0]        rd_re,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_we,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  // Port 1 is written last so it wins an address collision with port 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) regs[j] <= '0;
    end else begin
      if (we0 && (waddr0 != '0)) regs[waddr0] <= wdata0;
      if (we1 && (waddr1 != '0)) regs[waddr1] <= wdata1;
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [ADDR_W:0]  cnt_nxt;
  logic [ADDR_W:0]  pend_q;

  // Issue is applied after the write clears: the younger producer keeps the register busy.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (we0)    busy_nxt[waddr0]   = 1'b0;
      if (we1)    busy_nxt[waddr1]   = 1'b0;
      if (iss_we) busy_nxt[iss_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int j = 1; j < DEPTH; j++) cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[j]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= '0;
      pend_q <= '0;
    end else begin
      busy   <= busy_nxt;
      pend_q <= cnt_nxt;
    end
  end

  assign pend_cnt = pend_q;
`else
  logic unused_sb;
  assign unused_sb = ^{iss_we, iss_addr, flush};
  assign pend_cnt  = '0;
`endif

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              hit0;
    logic              hit1;
    assign a    = rd_addr[i*ADDR_W +: ADDR_W];
    assign hit0 = we0 && (waddr0 == a);
    assign hit1 = we1 && (waddr1 == a);

    assign rd_data[i*DATA_W +: DATA_W] =
      (rst || (a == '0) || !rd_re[i]) ? '0 :
      hit1                            ? wdata1 :
      hit0                            ? wdata0 :
                                        regs[a];

`ifdef REGFILE_SCOREBOARD_EN
    // A write landing this cycle resolves the operand through the bypass.
    assign rd_busy[i] = !rst && rd_re[i] && (a != '0) && busy[a] && !hit0 && !hit1;
`else
    assign rd_busy[i] = 1'b0;
`endif
  end

endmodule
